// File: rtl/branch_flag_unit.sv
// Execute-stage branch resolver: holds Z/N/C flags, resolves jumps against them,
// and drives the PC load pulse plus the pipeline flush window.
module branch_flag_unit #(
    parameter int DATA_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        jump_type,
    input  logic              direct_jump,
    input  logic [DATA_W-1:0] target_in,
    input  logic [3:0]        alu_operation,
    input  logic              flag_we,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    output logic              jump_occured,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic              zf,
    output logic              nf,
    output logic              cf
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [3:0] OP_SETC  = 4'd11;
    localparam logic [3:0] OP_CLRC  = 4'd12;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nx;
    logic              taken;
    logic              jo_nx;
    logic              pl_nx;
    logic              fl_nx;
    logic [DATA_W-1:0] tgt_nx;
    logic              clr_z;
    logic              clr_n;
    logic              clr_c;
    logic              z_nx;
    logic              n_nx;
    logic              c_nx;

    // Resolution uses the flags as registered, before this cycle's update
    assign taken = direct_jump
                 | ((jump_type == 2'd1) & zf)
                 | ((jump_type == 2'd2) & nf)
                 | ((jump_type == 2'd3) & cf);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        jo_nx    = 1'b0;
        pl_nx    = 1'b0;
        fl_nx    = flush;
        tgt_nx   = pc_target;
        clr_z    = 1'b0;
        clr_n    = 1'b0;
        clr_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (taken) begin
                    state_nx = FLUSH;
                    jo_nx    = 1'b1;
                    pl_nx    = 1'b1;
                    fl_nx    = 1'b1;
                    tgt_nx   = target_in;
                    cnt_nx   = CNT_INIT;
                    if (!direct_jump) begin
                        clr_z = (jump_type == 2'd1);
                        clr_n = (jump_type == 2'd2);
                        clr_c = (jump_type == 2'd3);
                    end
                end
            end
            FLUSH: begin
                // Requests here come from squashed instructions
                if (cnt == 3'd0) begin
                    fl_nx    = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        z_nx = zf;
        n_nx = nf;
        c_nx = cf;
        if (clr_z)
            z_nx = 1'b0;
        else if (flag_we)
            z_nx = alu_z;
        if (clr_n)
            n_nx = 1'b0;
        else if (flag_we)
            n_nx = alu_n;
        if (clr_c)
            c_nx = 1'b0;
        else if (alu_operation == OP_SETC)
            c_nx = 1'b1;
        else if (alu_operation == OP_CLRC)
            c_nx = 1'b0;
        else if (flag_we)
            c_nx = alu_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            jump_occured <= 1'b0;
            pc_load      <= 1'b0;
            pc_target    <= '0;
            flush        <= 1'b0;
            zf           <= 1'b0;
            nf           <= 1'b0;
            cf           <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            jump_occured <= jo_nx;
            pc_load      <= pl_nx;
            pc_target    <= tgt_nx;
            flush        <= fl_nx;
            zf           <= z_nx;
            nf           <= n_nx;
            cf           <= c_nx;
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: directed vectors queue expected outputs,
// a monitor compares them one step after each clock edge.
module tb_branch_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  jump_type;
    logic        direct_jump;
    logic [15:0] target_in;
    logic [3:0]  alu_operation;
    logic        flag_we;
    logic        alu_z;
    logic        alu_n;
    logic        alu_c;

    logic        jo, pl, fl, zf, nf, cf;
    logic [15:0] tgt;
    logic        jo1, pl1, fl1, zf1, nf1, cf1;
    logic [15:0] tgt1;
    logic        jo3, pl3, fl3, zf3, nf3, cf3;
    logic [15:0] tgt3;

    int checks = 0;
    int fails  = 0;

    logic [21:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    branch_flag_unit #(.DATA_W(16), .FLUSH_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .jump_type(jump_type), .direct_jump(direct_jump),
        .target_in(target_in), .alu_operation(alu_operation), .flag_we(flag_we),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .jump_occured(jo), .pc_load(pl), .pc_target(tgt), .flush(fl),
        .zf(zf), .nf(nf), .cf(cf)
    );

    branch_flag_unit #(.DATA_W(16), .FLUSH_CYCLES(1)) u_fc1 (
        .clk(clk), .rst(rst), .jump_type(jump_type), .direct_jump(direct_jump),
        .target_in(target_in), .alu_operation(alu_operation), .flag_we(flag_we),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .jump_occured(jo1), .pc_load(pl1), .pc_target(tgt1), .flush(fl1),
        .zf(zf1), .nf(nf1), .cf(cf1)
    );

    branch_flag_unit #(.DATA_W(16), .FLUSH_CYCLES(3)) u_fc3 (
        .clk(clk), .rst(rst), .jump_type(jump_type), .direct_jump(direct_jump),
        .target_in(target_in), .alu_operation(alu_operation), .flag_we(flag_we),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .jump_occured(jo3), .pc_load(pl3), .pc_target(tgt3), .flush(fl3),
        .zf(zf3), .nf(nf3), .cf(cf3)
    );

    // Packed layout: {jump_occured, pc_load, pc_target, flush, zf, nf, cf}
    function automatic logic [21:0] ex(input logic j, input logic p,
                                       input logic [15:0] t, input logic f,
                                       input logic z, input logic n, input logic c);
        return {j, p, t, f, z, n, c};
    endfunction

    task automatic step(input logic r, input logic [1:0] jt, input logic dj,
                        input logic [15:0] tg, input logic [3:0] op,
                        input logic we, input logic z, input logic n, input logic c,
                        input logic [21:0] e, input string nm);
        @(negedge clk);
        rst           = r;
        jump_type     = jt;
        direct_jump   = dj;
        target_in     = tg;
        alu_operation = op;
        flag_we       = we;
        alu_z         = z;
        alu_n         = n;
        alu_c         = c;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input logic [21:0] e, input string nm);
        step(0, 2'd0, 0, 16'h0, 4'd0, 0, 0, 0, 0, e, nm);
    endtask

    always begin
        logic [21:0] act;
        logic [21:0] e;
        string       nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {jo, pl, tgt, fl, zf, nf, cf};
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got jo=%b pl=%b tgt=%h fl=%b z=%b n=%b c=%b, want jo=%b pl=%b tgt=%h fl=%b z=%b n=%b c=%b",
                         nm, act[21], act[20], act[19:4], act[3], act[2], act[1], act[0],
                         e[21], e[20], e[19:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        int n1, n2, n3;
        rst = 1'b1; jump_type = 2'd0; direct_jump = 1'b0; target_in = 16'h0;
        alu_operation = 4'd0; flag_we = 1'b0; alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0;

        for (int i = 0; i < 2; i++)
            step(1, 2'($urandom), 1'($urandom), 16'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ex(0, 0, 16'h0, 0, 0, 0, 0), "rst");
        idle(ex(0, 0, 16'h0, 0, 0, 0, 0), "post_rst");

        step(0, 2'd0, 0, 16'h0, 4'd0, 1, 1, 0, 0, ex(0, 0, 16'h0, 0, 1, 0, 0), "ld_z");
        step(0, 2'd1, 0, 16'h0040, 4'd0, 0, 0, 0, 0, ex(1, 1, 16'h0040, 1, 0, 0, 0), "jz_take");
        idle(ex(0, 0, 16'h0040, 1, 0, 0, 0), "jz_fl1");
        idle(ex(0, 0, 16'h0040, 0, 0, 0, 0), "jz_fl_end");

        step(0, 2'd2, 0, 16'h0077, 4'd0, 0, 0, 0, 0, ex(0, 0, 16'h0040, 0, 0, 0, 0), "jn_not_taken");

        step(0, 2'd0, 0, 16'h0, 4'd11, 0, 0, 0, 0, ex(0, 0, 16'h0040, 0, 0, 0, 1), "setc");
        step(0, 2'd3, 0, 16'h1234, 4'd0, 0, 0, 0, 0, ex(1, 1, 16'h1234, 1, 0, 0, 0), "jc_take");
        idle(ex(0, 0, 16'h1234, 1, 0, 0, 0), "jc_fl1");
        step(0, 2'd0, 0, 16'h0, 4'd12, 1, 0, 0, 1, ex(0, 0, 16'h1234, 0, 0, 0, 0), "clrc_we");
        step(0, 2'd0, 0, 16'h0, 4'd11, 1, 1, 0, 0, ex(0, 0, 16'h1234, 0, 1, 0, 1), "setc_we");

        step(0, 2'd1, 0, 16'h00aa, 4'd0, 0, 0, 0, 0, ex(1, 1, 16'h00aa, 1, 0, 0, 1), "jz_take2");
        step(0, 2'd0, 0, 16'h0, 4'd0, 1, 1, 0, 1, ex(0, 0, 16'h00aa, 1, 1, 0, 1), "flush_ld_z");
        step(0, 2'd1, 0, 16'h0bad, 4'd0, 0, 0, 0, 0, ex(0, 0, 16'h00aa, 0, 1, 0, 1), "flush_ignore");
        idle(ex(0, 0, 16'h00aa, 0, 1, 0, 1), "idle_quiet");

        step(0, 2'd1, 1, 16'h0200, 4'd0, 0, 0, 0, 0, ex(1, 1, 16'h0200, 1, 1, 0, 1), "dj_with_jz");
        step(0, 2'd0, 1, 16'h0300, 4'd0, 0, 0, 0, 0, ex(0, 0, 16'h0200, 1, 1, 0, 1), "dj_dropped");
        idle(ex(0, 0, 16'h0200, 0, 1, 0, 1), "dj_fl_end");

        step(0, 2'd1, 0, 16'h0044, 4'd0, 1, 1, 1, 1, ex(1, 1, 16'h0044, 1, 0, 1, 1), "jz_with_we");
        step(1, 2'd1, 1, 16'hffff, 4'd11, 1, 1, 1, 1, ex(0, 0, 16'h0, 0, 0, 0, 0), "rst_in_flush");
        idle(ex(0, 0, 16'h0, 0, 0, 0, 0), "post_rst2");

        step(0, 2'd0, 0, 16'h0, 4'd0, 1, 0, 1, 0, ex(0, 0, 16'h0, 0, 0, 1, 0), "ld_n");
        step(0, 2'd2, 0, 16'h8000, 4'd0, 0, 0, 0, 0, ex(1, 1, 16'h8000, 1, 0, 0, 0), "jn_take");
        idle(ex(0, 0, 16'h8000, 1, 0, 0, 0), "jn_fl1");
        idle(ex(0, 0, 16'h8000, 0, 0, 0, 0), "jn_fl_end");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        // Flush window length for FLUSH_CYCLES = 1, 2, 3
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        direct_jump = 1'b1;
        target_in = 16'h0123;
        @(negedge clk);
        direct_jump = 1'b0;
        n1 = 0; n2 = 0; n3 = 0;
        for (int i = 0; i < 10; i++) begin
            n1 += int'(fl1);
            n2 += int'(fl);
            n3 += int'(fl3);
            @(negedge clk);
        end
        checks++;
        if (n1 != 1) begin
            fails++;
            $display("FAIL window_fc1: flush high %0d cycles, want 1", n1);
        end
        checks++;
        if (n2 != 2) begin
            fails++;
            $display("FAIL window_fc2: flush high %0d cycles, want 2", n2);
        end
        checks++;
        if (n3 != 3) begin
            fails++;
            $display("FAIL window_fc3: flush high %0d cycles, want 3", n3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
